// File: rtl/rc_pwm_pkg.sv
// Shared types and default timing constants for the RC PWM generator.
// Widths are in clock cycles (1 cycle = 1 us at the 1 MHz board clock).
package rc_pwm_pkg;

    localparam int WIDTH_W              = 11;
    localparam int DEF_FRAME_PERIOD     = 20000;
    localparam int DEF_MIN_PULSE        = 1000;
    localparam int DEF_MAX_PULSE        = 2000;
    localparam int DEF_NEUTRAL_PULSE    = 1500;
    localparam int DEF_FAILSAFE_FRAMES  = 50;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_t;

    function automatic logic [WIDTH_W-1:0] clamp_width(
        input logic [WIDTH_W-1:0] w,
        input logic [WIDTH_W-1:0] lo,
        input logic [WIDTH_W-1:0] hi
    );
        logic [WIDTH_W-1:0] r;
        if (w < lo) begin
            r = lo;
        end else if (w > hi) begin
            r = hi;
        end else begin
            r = w;
        end
        return r;
    endfunction

endpackage

// File: rtl/rc_pwm_frame_timer.sv
// Frame position counter: wraps every FRAME_PERIOD cycles and flags the last
// HIGH cycle and the last cycle of the frame.
module rc_pwm_frame_timer
    import rc_pwm_pkg::*;
#(
    parameter int FRAME_PERIOD = DEF_FRAME_PERIOD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               run,
    input  logic [WIDTH_W-1:0] high_len,
    output logic               high_done,
    output logic               frame_end
);

    localparam int CNT_W = $clog2(FRAME_PERIOD);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PERIOD - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] high_last_s;

    assign high_last_s = CNT_W'(high_len) - CNT_W'(1'b1);
    assign high_done   = (count_r == high_last_s);
    assign frame_end   = (count_r == LAST_CNT);

    // Position within the frame; restarts at a frame start or wrap, holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (start || frame_end) begin
            count_r <= '0;
        end else if (run) begin
            count_r <= count_r + CNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/rc_pwm_generator.sv
// RC servo/ESC PWM encoder: handshaked width command into a shadow register,
// applied only at frame starts. Optional failsafe under RC_PWM_FAILSAFE_EN.
module rc_pwm_generator
    import rc_pwm_pkg::*;
#(
    parameter int FRAME_PERIOD    = DEF_FRAME_PERIOD,
    parameter int MIN_PULSE       = DEF_MIN_PULSE,
    parameter int MAX_PULSE       = DEF_MAX_PULSE,
    parameter int NEUTRAL_PULSE   = DEF_NEUTRAL_PULSE,
    parameter int FAILSAFE_FRAMES = DEF_FAILSAFE_FRAMES
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               enable_i,
    input  logic [WIDTH_W-1:0] width_i,
    input  logic               width_valid_i,
    output logic               width_ready_o,
    output logic               pwm_o,
    output logic               frame_start_o,
    output logic [WIDTH_W-1:0] active_width_o,
    output logic               clamped_o,
    output logic               failsafe_o
);

    localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_PULSE);
    localparam logic [WIDTH_W-1:0] MAX_W     = WIDTH_W'(MAX_PULSE);
    localparam logic [WIDTH_W-1:0] NEUTRAL_W = WIDTH_W'(NEUTRAL_PULSE);

    pwm_state_t         state_r;
    logic               pwm_r;
    logic               frame_start_r;
    logic               clamped_r;
    logic               pending_r;
    logic [WIDTH_W-1:0] shadow_r;
    logic [WIDTH_W-1:0] active_r;

    logic               high_done_s;
    logic               frame_end_s;
    logic               begin_frame_s;
    logic               accept_s;
    logic               out_of_range_s;
    logic               run_s;

    // Ready is simply "no command waiting", so an accept can never coincide with a load.
    assign width_ready_o  = ~pending_r;
    assign accept_s       = width_valid_i & ~pending_r;
    assign out_of_range_s = (width_i < MIN_W) | (width_i > MAX_W);
    assign run_s          = (state_r != ST_IDLE);

    assign pwm_o          = pwm_r;
    assign frame_start_o  = frame_start_r;
    assign active_width_o = active_r;
    assign clamped_o      = clamped_r;

    // A new frame begins from IDLE, or at the wrap of a LOW phase, while enabled.
    always_comb begin
        begin_frame_s = 1'b0;
        case (state_r)
            ST_IDLE: begin_frame_s = enable_i;
            ST_LOW:  begin_frame_s = frame_end_s & enable_i;
            default: begin_frame_s = 1'b0;
        endcase
    end

    rc_pwm_frame_timer #(
        .FRAME_PERIOD (FRAME_PERIOD)
    ) u_timer (
        .clk       (clock_i),
        .rst_n     (reset_n_i),
        .start     (begin_frame_s),
        .run       (run_s),
        .high_len  (active_r),
        .high_done (high_done_s),
        .frame_end (frame_end_s)
    );

    // Frame FSM with registered pwm and frame-start outputs.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= ST_IDLE;
            pwm_r         <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (begin_frame_s) begin
            state_r       <= ST_HIGH;
            pwm_r         <= 1'b1;
            frame_start_r <= 1'b1;
        end else begin
            frame_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                    pwm_r   <= 1'b0;
                end
                ST_HIGH: begin
                    if (high_done_s) begin
                        state_r <= ST_LOW;
                        pwm_r   <= 1'b0;
                    end else begin
                        state_r <= ST_HIGH;
                        pwm_r   <= 1'b1;
                    end
                end
                ST_LOW: begin
                    pwm_r <= 1'b0;
                    if (frame_end_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOW;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    pwm_r   <= 1'b0;
                end
            endcase
        end
    end

    // Command handshake: clamp into the shadow register, release it at the next frame start.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shadow_r  <= NEUTRAL_W;
            pending_r <= 1'b0;
            clamped_r <= 1'b0;
        end else begin
            clamped_r <= accept_s & out_of_range_s;
            if (accept_s) begin
                shadow_r  <= clamp_width(width_i, MIN_W, MAX_W);
                pending_r <= 1'b1;
            end else if (begin_frame_s && pending_r) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

`ifdef RC_PWM_FAILSAFE_EN
    localparam int FS_W = $clog2(FAILSAFE_FRAMES + 1);
    localparam logic [FS_W-1:0] FS_LAST = FS_W'(FAILSAFE_FRAMES - 1);
    localparam logic [FS_W-1:0] FS_SAT  = FS_W'(FAILSAFE_FRAMES);

    logic [FS_W-1:0] stale_frames_r;
    logic            failsafe_r;

    assign failsafe_o = failsafe_r;

    // Active width update; frames without a fresh command eventually fall back to neutral.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            active_r       <= NEUTRAL_W;
            failsafe_r     <= 1'b0;
            stale_frames_r <= '0;
        end else if (begin_frame_s) begin
            if (pending_r) begin
                active_r       <= shadow_r;
                failsafe_r     <= 1'b0;
                stale_frames_r <= '0;
            end else if (stale_frames_r >= FS_LAST) begin
                active_r       <= NEUTRAL_W;
                failsafe_r     <= 1'b1;
                stale_frames_r <= FS_SAT;
            end else begin
                stale_frames_r <= stale_frames_r + FS_W'(1'b1);
            end
        end else if (state_r == ST_IDLE) begin
            stale_frames_r <= '0;
        end else begin
            stale_frames_r <= stale_frames_r;
        end
    end
`else
    assign failsafe_o = 1'b0;

    // Active width update: the last commanded width is held indefinitely.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            active_r <= NEUTRAL_W;
        end else if (begin_frame_s && pending_r) begin
            active_r <= shadow_r;
        end else begin
            active_r <= active_r;
        end
    end
`endif

endmodule

// File: doc/rc_pwm_generator.md
Name: rc_pwm_generator

Overview:
Encoder counterpart of the per-channel RC pulse demodulator: generates a standard RC servo/ESC PWM frame from a commanded pulse width in clock cycles (1 cycle = 1 us at the 1 MHz board clock). A command is written through a valid/ready handshake into a shadow register and applied only at a frame boundary, so pulses are never glitched. Eight instances drive loopback or servo outputs alongside the existing demodulator channels.

Parameters:
FRAME_PERIOD, 20000, frame length in cycles (20 ms)
MIN_PULSE, 1000, lowest legal pulse width in cycles
MAX_PULSE, 2000, highest legal pulse width in cycles
NEUTRAL_PULSE, 1500, width used after reset (and for failsafe)
FAILSAFE_FRAMES, 50, consecutive frames without a command before failsafe (FAILSAFE_EN only)

Ports:
clock_i  input  1  single clock, 1 MHz nominal
reset_n_i  input  1  reset, asynchronous, active-low
enable_i  input  1  run request; frames start/continue while high
width_i  input  11  commanded pulse width in cycles
width_valid_i  input  1  command valid
width_ready_o  output  1  shadow register free; transfer when valid and ready
pwm_o  output  1  registered PWM output
frame_start_o  output  1  one-cycle pulse in the first HIGH cycle of each frame
active_width_o  output  11  width used by the current frame
clamped_o  output  1  one-cycle pulse when an accepted command was clamped
failsafe_o  output  1  failsafe active (tied 0 without FAILSAFE_EN)

Behaviour:
- Reset (async assert, sync release): state IDLE, pwm_o=0, frame_start_o=0, clamped_o=0, failsafe_o=0, width_ready_o=1, pending=0, shadow=active_width_o=NEUTRAL_PULSE, counter=0.
- Reset mid-frame: pwm_o drops to 0 immediately, no pulse completion.
- Accept: width_valid_i && width_ready_o -> shadow <= clamp(width_i), pending <= 1, width_ready_o <= 0 next cycle. Clamp: <MIN_PULSE -> MIN_PULSE, >MAX_PULSE -> MAX_PULSE; clamped_o pulses in the cycle after acceptance if clamping applied.
- States: IDLE, HIGH, LOW. Counter width $clog2(FRAME_PERIOD), counts 0..FRAME_PERIOD-1 per frame.
- IDLE -> HIGH when enable_i=1: counter=0, frame_start_o=1, pwm_o=1. If pending: active_width_o <= shadow, pending <= 0, width_ready_o <= 1.
- HIGH for exactly active_width_o cycles (counter 0..active-1), then LOW until counter=FRAME_PERIOD-1.
- At end of LOW: enable_i=1 -> HIGH (new frame, same load rule); enable_i=0 -> IDLE. Deasserting enable_i never truncates a frame.
- Accept in the same cycle as a frame-start load: load uses the old shadow (pending was 0, active unchanged); the new command applies next frame.
- pwm_o period is exactly FRAME_PERIOD cycles; high time equals active_width_o, always within [MIN_PULSE, MAX_PULSE].
- Commands during IDLE are accepted and applied at the next frame start.

Optional Feature:
RC_PWM_FAILSAFE_EN
- Defined: a frame counter counts frame starts with no load from shadow. When it reaches FAILSAFE_FRAMES, active_width_o <= NEUTRAL_PULSE at that frame start and failsafe_o <= 1. Any accepted command clears failsafe_o on its load and resets the count. The count resets on reset and in IDLE.
- Undefined: no counter; the last width is held indefinitely; failsafe_o tied 0.

Decomposition:
- Shared package rc_pwm_pkg: state encoding (IDLE/HIGH/LOW), default timing constants (20000/1000/2000/1500), and the width constant 11.
- One natural sub-module, rc_pwm_frame_timer: frame counter with high/end-of-frame flags. The top level holds the handshake, clamp, shadow and FSM.

Test Plan:
- Reset then enable_i=1, no command -> frame_start_o every 20000 cycles; pwm_o high 1500 cycles per frame; width_ready_o=1.
- Write width 1200 mid-frame -> ready low until next frame start; that frame pwm_o high 1200 cycles; the current frame stays at 1500.
- Write 500, then 2047 -> active 1000 then 2000; clamped_o pulses once per write; 1800 -> clamped_o stays 0.
- Drop enable_i at cycle 300 of a frame -> full 1500-cycle pulse and the remaining LOW complete, then IDLE with pwm_o=0; no further frame_start_o.
- Assert reset_n_i=0 at cycle 700 of the HIGH phase -> pwm_o=0 the same cycle; after release, active_width_o=1500 and pending cleared.
- With RC_PWM_FAILSAFE_EN: command 1900 then no writes -> failsafe_o=1 and width 1500 from frame 51; new write 1100 -> failsafe_o=0 and width 1100 next frame.
